mem_req_arbiter: RTL and testbench

- Shares one core-side data memory port between NUM_INPUTS requesters (LSU lanes, SFU/CSR side loads) using round-robin arbitration.
- Tags each forwarded request with the requester index and steers responses back by that index.
- Tracks outstanding reads per requester to throttle each one and to drive a core busy indication.
- Sits between the execute-stage memory clients and the shared-memory/dcache bus.

---
 rtl/mem_req_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 561 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one core-side data memory port between NUM_INPUTS requesters.
//   Requests are picked round-robin, tagged with the requester index in the
//   tag LSBs and pushed through a 2-entry skid buffer toward the memory bus.
//   Responses are steered back to the requester named by the tag LSBs.
//   Per-requester outstanding-read counters throttle reads and feed busy.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_req_*            : per-requester request channel (flattened vectors)
//   in_req_ready        : per-requester accept (at most one bit set)
//   out_req_*           : merged request toward memory, driven from the buffer head
//   out_req_ready       : memory-side accept
//   out_rsp_*           : response from memory, tag = {requester tag, index}
//   in_rsp_valid        : one-hot routed response valid
//   in_rsp_data/tag     : response payload, broadcast to all requesters
//   in_rsp_ready        : per-requester response accept
//   busy                : any read outstanding or any request still buffered
module mem_req_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_SIZE   = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  localparam int IDX_W      = $clog2(NUM_INPUTS),
  localparam int OUT_TAG_W  = TAG_WIDTH + IDX_W,
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_INPUTS-1:0]             in_req_valid,
  input  logic [NUM_INPUTS-1:0]             in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]  in_req_addr,
  input  logic [NUM_INPUTS*DATA_SIZE-1:0]   in_req_byteen,
  input  logic [NUM_INPUTS*DATA_SIZE*8-1:0] in_req_data,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]   in_req_tag,
  output logic [NUM_INPUTS-1:0]             in_req_ready,
  output logic                              out_req_valid,
  output logic                              out_req_rw,
  output logic [ADDR_WIDTH-1:0]             out_req_addr,
  output logic [DATA_SIZE-1:0]              out_req_byteen,
  output logic [DATA_SIZE*8-1:0]            out_req_data,
  output logic [OUT_TAG_W-1:0]              out_req_tag,
  input  logic                              out_req_ready,
  input  logic                              out_rsp_valid,
  input  logic [DATA_SIZE*8-1:0]            out_rsp_data,
  input  logic [OUT_TAG_W-1:0]              out_rsp_tag,
  output logic                              out_rsp_ready,
  output logic [NUM_INPUTS-1:0]             in_rsp_valid,
  output logic [DATA_SIZE*8-1:0]            in_rsp_data,
  output logic [TAG_WIDTH-1:0]              in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]             in_rsp_ready,
  output logic                              busy
);

  localparam int DATA_W  = DATA_SIZE * 8;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_SIZE + DATA_W + OUT_TAG_W;

  logic [IDX_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]      pend [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] grant;
  logic                  any_grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_INPUTS-1:0] in_fire;
  logic [NUM_INPUTS-1:0] rd_inc;
  logic [NUM_INPUTS-1:0] rsp_dec;

  logic [ENTRY_W-1:0]    skid_mem [2];
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head;
  logic                  skid_wr_ptr;
  logic                  skid_rd_ptr;
  logic [1:0]            skid_count;
  logic [1:0]            skid_count_next;
  logic                  accept;
  logic                  push;
  logic                  pop;

  logic [IDX_W-1:0]      rsp_idx;
  logic                  rsp_fire;
  logic                  any_pend;

  // Reads stop being eligible once their requester hits the outstanding
  // limit; writes never get a response, so they are never throttled.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      eligible[i] = in_req_valid[i] &&
                    !(!in_req_rw[i] && (pend[i] == CNT_W'(MAX_PENDING)));
    end
  end

  // Round-robin search starting at rr_ptr: first pass covers indices at or
  // above the pointer, second pass wraps to the ones below it.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!any_grant && eligible[i] && (IDX_W'(i) >= rr_ptr)) begin
        any_grant = 1'b1;
        grant_idx = IDX_W'(i);
        grant[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!any_grant && eligible[i] && (IDX_W'(i) < rr_ptr)) begin
        any_grant = 1'b1;
        grant_idx = IDX_W'(i);
        grant[i]  = 1'b1;
      end
    end
  end

  // A full buffer still accepts when its head leaves this same cycle.
  // Ready is held low during reset so nothing is handed over and then dropped.
  assign accept       = (skid_count != 2'd2) || out_req_ready;
  assign in_req_ready = (accept && !reset) ? grant : '0;
  assign in_fire      = in_req_valid & in_req_ready;
  assign push         = |in_fire;
  assign pop          = out_req_valid && out_req_ready;

  // Payload of the granted requester, with its index appended to the tag.
  always_comb begin
    push_entry = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        push_entry = {in_req_rw[i],
                      in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                      in_req_byteen[i*DATA_SIZE +: DATA_SIZE],
                      in_req_data[i*DATA_W +: DATA_W],
                      in_req_tag[i*TAG_WIDTH +: TAG_WIDTH],
                      IDX_W'(i)};
      end
    end
  end

  // Skid storage holds payload only; validity lives in skid_count.
  always_ff @(posedge clk) begin
    if (push) begin
      skid_mem[skid_wr_ptr] <= push_entry;
    end
  end

  assign head = skid_mem[skid_rd_ptr];
  assign {out_req_rw, out_req_addr, out_req_byteen, out_req_data, out_req_tag} = head;

  always_comb begin
    unique case ({push, pop})
      2'b10:   skid_count_next = skid_count + 2'd1;
      2'b01:   skid_count_next = skid_count - 2'd1;
      default: skid_count_next = skid_count;
    endcase
  end

  // Buffer pointers, occupancy, registered valid and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      skid_wr_ptr   <= 1'b0;
      skid_rd_ptr   <= 1'b0;
      skid_count    <= 2'd0;
      out_req_valid <= 1'b0;
    end else begin
      if (push) begin
        skid_wr_ptr <= ~skid_wr_ptr;
        rr_ptr      <= (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if (pop) begin
        skid_rd_ptr <= ~skid_rd_ptr;
      end
      skid_count    <= skid_count_next;
      out_req_valid <= (skid_count_next != 2'd0);
    end
  end

  // Response steering: the index in the tag LSBs selects both the valid bit
  // raised and the ready bit returned to memory.
  assign rsp_idx     = out_rsp_tag[IDX_W-1:0];
  assign in_rsp_data = out_rsp_data;
  assign in_rsp_tag  = out_rsp_tag[OUT_TAG_W-1:IDX_W];

  always_comb begin
    out_rsp_ready = 1'b0;
    in_rsp_valid  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rsp_idx == IDX_W'(i)) begin
        out_rsp_ready   = in_rsp_ready[i];
        in_rsp_valid[i] = out_rsp_valid;
      end
    end
  end

  assign rsp_fire = out_rsp_valid && out_rsp_ready;

  always_comb begin
    rd_inc  = '0;
    rsp_dec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      rd_inc[i]  = in_fire[i] && !in_req_rw[i];
      rsp_dec[i] = rsp_fire && (rsp_idx == IDX_W'(i));
    end
  end

  // Outstanding-read counters; a same-cycle issue and return cancel out.
  // A stray decrement at zero leaves the counter at zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (reset) begin
        pend[i] <= '0;
      end else if (rd_inc[i] && !rsp_dec[i]) begin
        pend[i] <= pend[i] + CNT_W'(1);
      end else if (!rd_inc[i] && rsp_dec[i] && (pend[i] != '0)) begin
        pend[i] <= pend[i] - CNT_W'(1);
      end
    end
  end

  // Simulation-time protocol checks on the response side.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (rsp_dec[i]) begin
          assert (pend[i] != '0);
        end
      end
      if (out_rsp_valid) begin
        assert (int'(rsp_idx) < NUM_INPUTS);
      end
    end
  end

  always_comb begin
    any_pend = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      any_pend = any_pend || (pend[i] != '0);
    end
  end

  assign busy = any_pend || (skid_count != 2'd0);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//   Self-checking bench for mem_req_arbiter with default parameters.
//   Each scenario task drives stimulus and checks cycle-level behaviour
//   inline; every request expected on the memory side is also pushed to a
//   scoreboard queue and compared in order when it leaves the DUT.
module tb_mem_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DS = 4;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int OW = 10;

  typedef struct packed {
    logic [OW-1:0] tag;
    logic [AW-1:0] addr;
    logic          rw;
    logic [DS-1:0] byteen;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [N-1:0]      in_req_valid;
  logic [N-1:0]      in_req_rw;
  logic [N*AW-1:0]   in_req_addr;
  logic [N*DS-1:0]   in_req_byteen;
  logic [N*DW-1:0]   in_req_data;
  logic [N*TW-1:0]   in_req_tag;
  logic [N-1:0]      in_req_ready;
  logic              out_req_valid;
  logic              out_req_rw;
  logic [AW-1:0]     out_req_addr;
  logic [DS-1:0]     out_req_byteen;
  logic [DW-1:0]     out_req_data;
  logic [OW-1:0]     out_req_tag;
  logic              out_req_ready;
  logic              out_rsp_valid;
  logic [DW-1:0]     out_rsp_data;
  logic [OW-1:0]     out_rsp_tag;
  logic              out_rsp_ready;
  logic [N-1:0]      in_rsp_valid;
  logic [DW-1:0]     in_rsp_data;
  logic [TW-1:0]     in_rsp_tag;
  logic [N-1:0]      in_rsp_ready;
  logic              busy;

  logic [AW-1:0]     addr_a   [N];
  logic [DS-1:0]     byteen_a [N];
  logic [DW-1:0]     data_a   [N];
  logic [TW-1:0]     tag_a    [N];

  exp_t              sb [$];
  int                n_cmp;
  int                n_fail;

  mem_req_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_rw      (in_req_rw),
    .in_req_addr    (in_req_addr),
    .in_req_byteen  (in_req_byteen),
    .in_req_data    (in_req_data),
    .in_req_tag     (in_req_tag),
    .in_req_ready   (in_req_ready),
    .out_req_valid  (out_req_valid),
    .out_req_rw     (out_req_rw),
    .out_req_addr   (out_req_addr),
    .out_req_byteen (out_req_byteen),
    .out_req_data   (out_req_data),
    .out_req_tag    (out_req_tag),
    .out_req_ready  (out_req_ready),
    .out_rsp_valid  (out_rsp_valid),
    .out_rsp_data   (out_rsp_data),
    .out_rsp_tag    (out_rsp_tag),
    .out_rsp_ready  (out_rsp_ready),
    .in_rsp_valid   (in_rsp_valid),
    .in_rsp_data    (in_rsp_data),
    .in_rsp_tag     (in_rsp_tag),
    .in_rsp_ready   (in_rsp_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Flatten the per-requester payload arrays onto the DUT buses.
  always_comb begin
    in_req_addr   = '0;
    in_req_byteen = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    for (int i = 0; i < N; i++) begin
      in_req_addr[i*AW +: AW]   = addr_a[i];
      in_req_byteen[i*DS +: DS] = byteen_a[i];
      in_req_data[i*DW +: DW]   = data_a[i];
      in_req_tag[i*TW +: TW]    = tag_a[i];
    end
  end

  // Scoreboard consumer: a handshake seen at the falling edge completes on
  // the next rising edge, since inputs only change just after rising edges.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (!reset && out_req_valid && out_req_ready) begin
      got = {out_req_tag, out_req_addr, out_req_rw, out_req_byteen, out_req_data};
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sb_unexpected: got %h, expected no request", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("[TB] FAIL sb_order: got %h, expected %h", got, want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input int i);
    exp_t e;
    e.tag    = {tag_a[i], 2'(i)};
    e.addr   = addr_a[i];
    e.rw     = in_req_rw[i];
    e.byteen = byteen_a[i];
    e.data   = data_a[i];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    in_req_valid  = '0;
    in_req_rw     = '0;
    out_rsp_valid = 1'b0;
    out_req_ready = 1'b1;
    in_rsp_ready  = '1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    in_req_valid = '1;
    in_req_rw    = '0;
    tick();
    n_cmp++;
    if (in_req_ready !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b, expected 0000", in_req_ready);
    end
    in_req_valid = '0;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_req_valid);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", busy);
    end
    n_cmp++;
    if (in_rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_rsp_valid: got %b, expected 0000", in_rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'(32'h100 + i);
      tag_a[i]  = TW'(8'h10 + i);
    end
    in_req_rw    = '0;
    in_req_valid = '1;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rr_pre_valid: got %b, expected 0", out_req_valid);
    end
    for (int k = 0; k < 8; k++) begin
      w = k % N;
      n_cmp++;
      if (in_req_ready !== 4'(1 << w)) begin
        n_fail++;
        $display("[TB] FAIL rr_grant[%0d]: got %b, expected %b", k, in_req_ready, 4'(1 << w));
      end
      expect_req(w);
      tick();
      n_cmp++;
      if (out_req_valid !== 1'b1 || out_req_tag !== {tag_a[w], 2'(w)}) begin
        n_fail++;
        $display("[TB] FAIL rr_out[%0d]: got valid %b tag %h, expected valid 1 tag %h",
                 k, out_req_valid, out_req_tag, {tag_a[w], 2'(w)});
      end
    end
    // Only input 2 asserted: it must win every cycle whatever rr_ptr is.
    in_req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (in_req_ready !== 4'b0100) begin
        n_fail++;
        $display("[TB] FAIL single_grant[%0d]: got %b, expected 0100", k, in_req_ready);
      end
      expect_req(2);
      tick();
    end
    in_req_valid = '0;
    tick();
    tick();
    n_cmp++;
    if (out_req_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rr_drain: got valid %b busy %b, expected valid 0 busy 1",
               out_req_valid, busy);
    end
  endtask

  task automatic test_tag_route();
    do_reset();
    addr_a[2]    = AW'(32'h2AA);
    tag_a[2]     = 8'h5A;
    in_req_rw    = '0;
    in_req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL route_grant: got %b, expected 0100", in_req_ready);
    end
    expect_req(2);
    tick();
    in_req_valid = '0;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b1 || out_req_tag !== 10'h16A) begin
      n_fail++;
      $display("[TB] FAIL route_out_tag: got valid %b tag %h, expected valid 1 tag 16a",
               out_req_valid, out_req_tag);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL route_busy_pending: got %b, expected 1", busy);
    end
    out_rsp_valid = 1'b1;
    out_rsp_tag   = 10'h16A;
    out_rsp_data  = 32'hDEADBEEF;
    in_rsp_ready  = '1;
    #1;
    n_cmp++;
    if (in_rsp_valid !== 4'b0100 || in_rsp_tag !== 8'h5A ||
        in_rsp_data !== 32'hDEADBEEF || out_rsp_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL route_rsp: got valid %b tag %h data %h ready %b, expected 0100 5a deadbeef 1",
               in_rsp_valid, in_rsp_tag, in_rsp_data, out_rsp_ready);
    end
    tick();
    out_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL route_busy_clear: got %b, expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_req_ready = 1'b0;
    in_req_rw     = '0;
    tag_a[0]      = 8'h30;
    addr_a[0]     = AW'(32'h1000);
    in_req_valid  = 4'b0001;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL bp_first_accept: got %b, expected 0001", in_req_ready);
    end
    expect_req(0);
    tick();
    addr_a[0] = AW'(32'h1001);
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001 || out_req_addr !== AW'(32'h1000)) begin
      n_fail++;
      $display("[TB] FAIL bp_second_accept: got ready %b addr %h, expected 0001 1000",
               in_req_ready, out_req_addr);
    end
    expect_req(0);
    tick();
    addr_a[0] = AW'(32'h1002);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (in_req_ready !== 4'b0000 || out_req_valid !== 1'b1 ||
          out_req_addr !== AW'(32'h1000) || out_req_tag !== 10'h0C0) begin
        n_fail++;
        $display("[TB] FAIL bp_stall[%0d]: got ready %b valid %b addr %h tag %h, expected 0000 1 1000 0c0",
                 k, in_req_ready, out_req_valid, out_req_addr, out_req_tag);
      end
      tick();
    end
    // Full buffer with the head leaving this cycle must still accept.
    out_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL bp_full_pop_accept: got %b, expected 0001", in_req_ready);
    end
    expect_req(0);
    tick();
    in_req_valid = '0;
    #1;
    n_cmp++;
    if (out_req_addr !== AW'(32'h1001)) begin
      n_fail++;
      $display("[TB] FAIL bp_drain1: got %h, expected 1001", out_req_addr);
    end
    tick();
    n_cmp++;
    if (out_req_addr !== AW'(32'h1002)) begin
      n_fail++;
      $display("[TB] FAIL bp_drain2: got %h, expected 1002", out_req_addr);
    end
    tick();
    n_cmp++;
    if (out_req_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_empty: got %b, expected 0", out_req_valid);
    end
  endtask

  // Continues from test_backpressure: input 0 has three reads outstanding.
  task automatic test_same_cycle();
    addr_a[0]     = AW'(32'h2000);
    in_req_rw     = '0;
    in_req_valid  = 4'b0001;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h77, 2'd0};
    out_rsp_data  = 32'h12345678;
    in_rsp_ready  = '1;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001 || out_rsp_ready !== 1'b1 || in_rsp_valid !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL same_cycle_fire: got ready %b rsp_ready %b rsp_valid %b, expected 0001 1 0001",
               in_req_ready, out_rsp_ready, in_rsp_valid);
    end
    expect_req(0);
    tick();
    in_req_valid = '0;
    in_rsp_ready = 4'b1110;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (out_rsp_ready !== 1'b0 || in_rsp_valid !== 4'b0001 || in_rsp_tag !== 8'h77) begin
        n_fail++;
        $display("[TB] FAIL rsp_hold[%0d]: got ready %b valid %b tag %h, expected 0 0001 77",
                 k, out_rsp_ready, in_rsp_valid, in_rsp_tag);
      end
      tick();
    end
    // Exactly three returns must bring the count to zero.
    in_rsp_ready = '1;
    for (int r = 0; r < 3; r++) begin
      tick();
      n_cmp++;
      if (busy !== (r < 2)) begin
        n_fail++;
        $display("[TB] FAIL pend_drain[%0d]: got busy %b, expected %b", r, busy, (r < 2));
      end
    end
    out_rsp_valid = 1'b0;
  endtask

  task automatic test_throttle();
    do_reset();
    in_req_rw = '0;
    tag_a[1]  = 8'h11;
    tag_a[3]  = 8'h33;
    addr_a[3] = AW'(32'h3300);
    in_req_valid = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      addr_a[1] = AW'(32'h3000 + k);
      #1;
      n_cmp++;
      if (in_req_ready !== 4'b0010) begin
        n_fail++;
        $display("[TB] FAIL thr_fill[%0d]: got %b, expected 0010", k, in_req_ready);
      end
      expect_req(1);
      tick();
    end
    addr_a[1]    = AW'(32'h30FF);
    in_req_valid = 4'b1010;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL thr_blocked_read: got %b, expected 1000", in_req_ready);
    end
    expect_req(3);
    tick();
    in_req_rw = 4'b0010;
    data_a[1] = 32'hCAFE0001;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL thr_write_passes: got %b, expected 0010", in_req_ready);
    end
    expect_req(1);
    tick();
    in_req_rw = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (in_req_ready !== 4'b1000) begin
        n_fail++;
        $display("[TB] FAIL thr_other_passes[%0d]: got %b, expected 1000", k, in_req_ready);
      end
      expect_req(3);
      tick();
    end
    in_req_valid  = 4'b0010;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h11, 2'd1};
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0000 || in_rsp_valid !== 4'b0010 || out_rsp_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL thr_rsp_cycle: got ready %b rsp_valid %b rsp_ready %b, expected 0000 0010 1",
               in_req_ready, in_rsp_valid, out_rsp_ready);
    end
    tick();
    out_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL thr_unblocked: got %b, expected 0010", in_req_ready);
    end
    expect_req(1);
    tick();
    in_req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_req_ready = 1'b0;
    in_req_rw     = '0;
    in_req_valid  = 4'b0011;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL mid_first: got %b, expected 0001", in_req_ready);
    end
    tick();
    n_cmp++;
    if (in_req_ready !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL mid_second: got %b, expected 0010", in_req_ready);
    end
    tick();
    in_req_valid = '0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || out_req_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_loaded: got busy %b valid %b, expected 1 1", busy, out_req_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_cleared: got valid %b busy %b, expected 0 0", out_req_valid, busy);
    end
    out_req_ready = 1'b1;
    addr_a[1]     = AW'(32'h4100);
    in_req_valid  = 4'b1010;
    #1;
    n_cmp++;
    if (in_req_ready !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL mid_ptr_reset: got %b, expected 0010", in_req_ready);
    end
    expect_req(1);
    tick();
    in_req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    clk           = 1'b0;
    reset         = 1'b1;
    n_cmp         = 0;
    n_fail        = 0;
    in_req_valid  = '0;
    in_req_rw     = '0;
    out_req_ready = 1'b1;
    out_rsp_valid = 1'b0;
    out_rsp_data  = '0;
    out_rsp_tag   = '0;
    in_rsp_ready  = '1;
    for (int i = 0; i < N; i++) begin
      addr_a[i]   = '0;
      byteen_a[i] = DS'(i + 1);
      data_a[i]   = 32'hD000_0000 + i;
      tag_a[i]    = '0;
    end
    test_reset();
    test_round_robin();
    test_tag_route();
    test_backpressure();
    test_same_cycle();
    test_throttle();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
